// File: rtl/cpu_ctrl_pkg.sv
// Shared control constants for the pipeline run controller:
// FSM state encodings and the halt sentinel instruction.
package cpu_ctrl_pkg;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_DRAIN  = 2'd2;
    localparam logic [1:0] S_HALTED = 2'd3;

    localparam logic [31:0] HALT_INSTR = 32'hFFFF_FFFF;

    function automatic logic is_halt(
        input logic        valid,
        input logic [31:0] instr
    );
        return valid && (instr == HALT_INSTR);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and count enable.
// Clear has priority; the count sticks at all-ones.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_run_ctrl.sv
// Run/halt controller: fetch gating, halt-sentinel drain,
// debug access to dmem after halt, and performance counters.
module pipeline_run_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int DRAIN_CYCLES = 5,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             if_valid,
    input  logic [31:0]      if_instr,
    input  logic             wb_valid,
    output logic             pc_en,
    output logic             if_id_flush,
    output logic             pipe_en,
    input  logic             dbg_req,
    output logic             dbg_grant,
    output logic             dmem_sel,
    output logic             end_program,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] retired_count
);

    localparam int DW = $clog2(DRAIN_CYCLES + 1);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

    logic [1:0]    state_q;
    logic [1:0]    state_d;
    logic [DW-1:0] drain_cnt;
    logic          in_run;
    logic          in_drain;
    logic          in_halted;
    logic          in_idle;
    logic          halt_hit;
    logic          drain_last;
    logic          cnt_clr;

    assign in_idle    = (state_q == S_IDLE);
    assign in_run     = (state_q == S_RUN);
    assign in_drain   = (state_q == S_DRAIN);
    assign in_halted  = (state_q == S_HALTED);
    assign halt_hit   = in_run && is_halt(if_valid, if_instr);
    assign drain_last = (drain_cnt == DRAIN_LAST);

    // The sentinel is squashed in the same cycle so it never reaches ID.
    assign pc_en       = in_run;
    assign pipe_en     = in_run || in_drain;
    assign if_id_flush = in_drain || halt_hit;
    assign dmem_sel    = in_halted;
    assign state       = state_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (start)      state_d = S_RUN;
            S_RUN:    if (halt_hit)   state_d = S_DRAIN;
            S_DRAIN:  if (drain_last) state_d = S_HALTED;
            S_HALTED: if (start)      state_d = S_RUN;
            default:                  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            drain_cnt   <= '0;
            end_program <= 1'b0;
            dbg_grant   <= 1'b0;
        end else begin
            state_q     <= state_d;
            end_program <= (state_d == S_HALTED);
            // A restart in the same cycle wins over a pending grant.
            dbg_grant   <= dbg_req && in_halted && !start;
            if (!in_drain) begin
                drain_cnt <= '0;
            end else if (!drain_last) begin
                drain_cnt <= drain_cnt + 1'b1;
            end
        end
    end

    assign cnt_clr = start && (in_idle || in_halted);

    sat_counter #(
        .W(CNT_W)
    ) u_cycle_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .en    (pipe_en),
        .count (cycle_count)
    );

    sat_counter #(
        .W(CNT_W)
    ) u_retired_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .en    (pipe_en && wb_valid),
        .count (retired_count)
    );

endmodule

// File: doc/pipeline_run_ctrl.md
PIPELINE_RUN_CTRL -- requirements
Module: pipeline_run_ctrl

Interface
REQ-001 SHALL have parameter DRAIN_CYCLES, default 5, the number of cycles allowed for the pipeline to empty after halt.
REQ-002 SHALL have parameter CNT_W, default 32, the width of both performance counters.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (0 = asserted).
REQ-005 SHALL have port start  input  1  run request; a pulse or level, sampled per cycle.
REQ-006 SHALL have ports if_valid  input  1 and if_instr  input  32, the instruction currently in IF.
REQ-007 SHALL have port wb_valid  input  1  an instruction retires in WB this cycle.
REQ-008 SHALL have port pc_en  output  1  PC and fetch advance enable.
REQ-009 SHALL have port if_id_flush  output  1  load a bubble into IF/ID.
REQ-010 SHALL have port pipe_en  output  1  enable for the ID/EX, EX/MEM and MEM/WB registers.
REQ-011 SHALL have port dbg_req  input  1  debug/dump agent requests data-memory access.
REQ-012 SHALL have ports dbg_grant  output  1 and dmem_sel  output  1 (dmem_sel: 0 = MEM stage owns dmem, 1 = debug port owns dmem).
REQ-013 SHALL have ports end_program  output  1 and state  output  2.
REQ-014 SHALL have ports cycle_count  output  CNT_W and retired_count  output  CNT_W.

Function
REQ-015 SHALL implement the FSM IDLE(0), RUN(1), DRAIN(2), HALTED(3); state reflects the registered state.
REQ-016 In IDLE: pc_en=0, pipe_en=0, if_id_flush=0, and counters hold; start=1 moves to RUN next cycle and clears both counters on that edge.
REQ-017 In RUN: pc_en=1, pipe_en=1, cycle_count increments every cycle, and retired_count increments in every cycle with wb_valid=1.
REQ-018 In RUN, if_valid=1 with if_instr=32'hFFFFFFFF (halt sentinel) SHALL assert if_id_flush combinationally in that same cycle and move to DRAIN next cycle; the sentinel never enters ID.
REQ-019 In DRAIN: pc_en=0, if_id_flush=1, pipe_en=1, and both counters keep counting; a drain counter moves the FSM to HALTED after exactly DRAIN_CYCLES DRAIN cycles.
REQ-020 In HALTED: pc_en=0, pipe_en=0, if_id_flush=0, end_program=1 (registered, first high on the HALTED entry edge), counters frozen, wb_valid ignored.
REQ-021 dmem_sel SHALL be 1 exactly when state==HALTED.
REQ-022 dbg_grant SHALL be registered: it is 1 in the cycle after a cycle with dbg_req=1 and state==HALTED, and 0 otherwise; dbg_req outside HALTED is never granted.
REQ-023 start in RUN or DRAIN SHALL be ignored; start in HALTED SHALL restart to RUN next cycle, clear both counters, and drop end_program, dbg_grant and dmem_sel.
REQ-024 Both counters SHALL saturate at all-ones and never wrap.
REQ-025 A halt sentinel with if_valid=0 SHALL be ignored; a sentinel seen outside RUN SHALL be ignored.

Reset
REQ-026 Reset assertion SHALL immediately force IDLE, regardless of current state, including mid-DRAIN or while granting.
REQ-027 Under reset, all registered outputs SHALL be 0: end_program, dbg_grant, cycle_count, retired_count, the drain counter, and state.
REQ-028 Under reset, pc_en, pipe_en, if_id_flush and dmem_sel SHALL also be 0.
REQ-029 Reset deassertion SHALL NOT start a run; an explicit start is required.

Structure
REQ-030 State encodings and the HALT_INSTR constant (32'hFFFFFFFF) SHALL live in shared package cpu_ctrl_pkg.
REQ-031 Both performance counters SHALL instantiate one sub-module, sat_counter (parameterised width; clear, enable and saturate).
REQ-032 The outputs pc_en, pipe_en, if_id_flush and dmem_sel SHALL be decoded from state, plus the REQ-018 halt term.

Verification
REQ-033 Reset, then start for 1 cycle, then 4 instructions retiring, then the sentinel -> state goes 1 then 2; end_program rises exactly 5 cycles after DRAIN entry; retired_count=4.
REQ-034 Sentinel presented with if_valid=0 during RUN -> FSM stays in RUN and if_id_flush stays 0.
REQ-035 dbg_req=1 in RUN, then held into HALTED -> dbg_grant=0 in RUN; dbg_grant=1 one cycle after HALTED entry; dmem_sel=1 throughout HALTED.
REQ-036 Reset asserted in the 3rd DRAIN cycle -> immediately state=0, all outputs 0, and no run until a new start.
REQ-037 CNT_W=4, with 20 RUN cycles -> cycle_count holds at 15 with no wrap.
REQ-038 start in HALTED -> RUN next cycle, counters 0 then counting, end_program=0.
